lsu_mem_port: RTL and testbench



---
 rtl/lsu_mem_port.sv | 193 +++++++++++++++++++
 tb/tb_lsu_mem_port.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: single-outstanding load/store initiator between the RV64I
// memory stage and a 64 KiB byte-addressed data memory. Checks range,
// alignment and funct3 legality, drives the byte write mask and store data
// for one ACCESS cycle, and returns sign/zero-extended load data over a
// valid/ready response handshake.
module lsu_mem_port (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic [7:0]  mem_w_mask,
  output logic [15:0] mem_address,
  output logic [63:0] mem_write_data,
  input  logic [63:0] mem_read_data
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 64;
  localparam int unsigned MW = DW / 8;
  localparam int unsigned F3W = 3;

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_RESP   = 2'd2;

  // funct3[1:0] encodes the access size for both signed and unsigned forms
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_D = 2'b11;

  logic [1:0]     state_q, state_d;
  logic           we_q, we_d;
  logic [F3W-1:0] funct3_q, funct3_d;
  logic           req_ready_q, req_ready_d;
  logic           resp_valid_q, resp_valid_d;
  logic           resp_err_q, resp_err_d;
  logic [DW-1:0]  rdata_q, rdata_d;
  logic [MW-1:0]  mask_q, mask_d;
  logic [AW-1:0]  addr_q, addr_d;
  logic [DW-1:0]  wdata_q, wdata_d;

  logic           req_err_c;
  logic           misalign_c;
  logic           range_err_c;
  logic           funct3_err_c;
  logic [MW-1:0]  req_mask_c;
  logic [DW-1:0]  load_ext_c;

  // Request legality: upper address bits, natural alignment, funct3 code
  always_comb begin
    range_err_c = |req_addr[63:AW];
    misalign_c  = 1'b0;
    case (req_funct3[1:0])
      SZ_B:    misalign_c = 1'b0;
      SZ_H:    misalign_c = req_addr[0];
      SZ_W:    misalign_c = |req_addr[1:0];
      SZ_D:    misalign_c = |req_addr[2:0];
      default: misalign_c = 1'b0;
    endcase
    if (req_we) begin
      funct3_err_c = req_funct3[2];
    end else begin
      funct3_err_c = (req_funct3 == 3'b111);
    end
    req_err_c = range_err_c | misalign_c | funct3_err_c;
  end

  // Byte write mask for the incoming store, low bytes first
  always_comb begin
    req_mask_c = '0;
    case (req_funct3[1:0])
      SZ_B:    req_mask_c = 8'b0000_0001;
      SZ_H:    req_mask_c = 8'b0000_0011;
      SZ_W:    req_mask_c = 8'b0000_1111;
      SZ_D:    req_mask_c = 8'b1111_1111;
      default: req_mask_c = '0;
    endcase
  end

  // Extend the little-endian read word according to the captured funct3
  always_comb begin
    load_ext_c = '0;
    case (funct3_q)
      3'b000:  load_ext_c = {{56{mem_read_data[7]}},  mem_read_data[7:0]};
      3'b001:  load_ext_c = {{48{mem_read_data[15]}}, mem_read_data[15:0]};
      3'b010:  load_ext_c = {{32{mem_read_data[31]}}, mem_read_data[31:0]};
      3'b011:  load_ext_c = mem_read_data;
      3'b100:  load_ext_c = {56'd0, mem_read_data[7:0]};
      3'b101:  load_ext_c = {48'd0, mem_read_data[15:0]};
      3'b110:  load_ext_c = {32'd0, mem_read_data[31:0]};
      default: load_ext_c = '0;
    endcase
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    we_d         = we_q;
    funct3_d     = funct3_q;
    rdata_d      = rdata_q;
    resp_err_d   = resp_err_q;
    mask_d       = mask_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;

    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d       = req_we;
          funct3_d   = req_funct3;
          rdata_d    = '0;
          resp_err_d = req_err_c;
          if (req_err_c) begin
            // Illegal requests skip the memory entirely
            state_d = S_RESP;
          end else begin
            state_d = S_ACCESS;
            addr_d  = req_addr[AW-1:0];
            if (req_we) begin
              wdata_d = req_wdata;
              mask_d  = req_mask_c;
            end
          end
        end
      end
      S_ACCESS: begin
        // Store commits at the closing edge; load samples the read word
        state_d = S_RESP;
        mask_d  = '0;
        if (!we_q) begin
          rdata_d = load_ext_c;
        end
      end
      S_RESP: begin
        if (resp_ready) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        mask_d  = '0;
      end
    endcase

    req_ready_d  = (state_d == S_IDLE);
    resp_valid_d = (state_d == S_RESP);
  end

  // State and output registers; async reset also aborts an in-flight store
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      we_q         <= 1'b0;
      funct3_q     <= '0;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      rdata_q      <= '0;
      mask_q       <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      we_q         <= we_d;
      funct3_q     <= funct3_d;
      req_ready_q  <= req_ready_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      rdata_q      <= rdata_d;
      mask_q       <= mask_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
    end
  end

  assign req_ready      = req_ready_q;
  assign resp_valid     = resp_valid_q;
  assign resp_err       = resp_err_q;
  assign resp_rdata     = rdata_q;
  assign mem_w_mask     = mask_q;
  assign mem_address    = addr_q;
  assign mem_write_data = wdata_q;

endmodule

// File: tb/tb_lsu_mem_port.sv
// Directed bench for lsu_mem_port with a 64 KiB byte-array memory model.
module tb_lsu_mem_port;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic [7:0]  mem_w_mask;
  logic [15:0] mem_address;
  logic [63:0] mem_write_data;
  logic [63:0] mem_read_data;

  logic [7:0]  mem [0:65535];

  int tests_run;
  int tests_failed;

  lsu_mem_port dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_we         (req_we),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_w_mask     (mem_w_mask),
    .mem_address    (mem_address),
    .mem_write_data (mem_write_data),
    .mem_read_data  (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model: combinational little-endian read, masked write on the edge
  always_comb begin
    mem_read_data = '0;
    for (int i = 0; i < 8; i++) begin
      mem_read_data[8*i +: 8] = mem[16'(mem_address + 16'(i))];
    end
  end

  always @(posedge clk) begin
    for (int i = 0; i < 8; i++) begin
      if (mem_w_mask[i]) mem[16'(mem_address + 16'(i))] <= mem_write_data[8*i +: 8];
    end
  end

  // Issue one request, wait (bounded) for its response and complete it
  task automatic do_req(input logic we, input logic [2:0] f3, input logic [63:0] a,
                        input logic [63:0] wd, output logic [63:0] rd, output logic e,
                        output logic [7:0] mk, output logic [15:0] ma,
                        output logic [63:0] mwd);
    logic seen;
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    mk = mem_w_mask; ma = mem_address; mwd = mem_write_data;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        seen = 1'b1;
        break;
      end
    end
    tests_run++;
    if (!seen) begin
      tests_failed++;
      $display("FAIL resp_timeout addr=%h got resp_valid=0 exp 1 within 8 cycles", a);
    end
    rd = resp_rdata; e = resp_err;
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    tests_run += 7;
    if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_req_ready got %b exp 1", req_ready); end
    if (resp_valid !== 1'b0) begin tests_failed++; $display("FAIL rst_resp_valid got %b exp 0", resp_valid); end
    if (resp_err !== 1'b0) begin tests_failed++; $display("FAIL rst_resp_err got %b exp 0", resp_err); end
    if (resp_rdata !== 64'd0) begin tests_failed++; $display("FAIL rst_rdata got %h exp 0", resp_rdata); end
    if (mem_w_mask !== 8'd0) begin tests_failed++; $display("FAIL rst_mask got %b exp 0", mem_w_mask); end
    if (mem_address !== 16'd0) begin tests_failed++; $display("FAIL rst_addr got %h exp 0", mem_address); end
    if (mem_write_data !== 64'd0) begin tests_failed++; $display("FAIL rst_wdata got %h exp 0", mem_write_data); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset_mid_access();
    logic [63:0] bytes;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b011;
    req_addr = 64'h0200; req_wdata = 64'hDEAD_BEEF_CAFE_F00D;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    tests_run++;
    if (mem_w_mask !== 8'hFF) begin tests_failed++; $display("FAIL mid_rst_mask_pre got %b exp 11111111", mem_w_mask); end
    #1;
    rst_n = 1'b0;
    #1;
    tests_run += 6;
    if (mem_w_mask !== 8'd0) begin tests_failed++; $display("FAIL mid_rst_mask got %b exp 0", mem_w_mask); end
    if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL mid_rst_req_ready got %b exp 1", req_ready); end
    if (resp_valid !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_resp_valid got %b exp 0", resp_valid); end
    if (resp_rdata !== 64'd0) begin tests_failed++; $display("FAIL mid_rst_rdata got %h exp 0", resp_rdata); end
    if (mem_address !== 16'd0) begin tests_failed++; $display("FAIL mid_rst_addr got %h exp 0", mem_address); end
    if (mem_write_data !== 64'd0) begin tests_failed++; $display("FAIL mid_rst_wdata got %h exp 0", mem_write_data); end
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) bytes[8*i +: 8] = mem[16'h0200 + 16'(i)];
    tests_run++;
    if (bytes !== 64'd0) begin tests_failed++; $display("FAIL mid_rst_mem got %h exp 0", bytes); end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_sd_ld();
    logic [63:0] rd, mwd; logic e; logic [7:0] mk; logic [15:0] ma;
    do_req(1'b1, 3'b011, 64'h0100, 64'h1122_3344_5566_7788, rd, e, mk, ma, mwd);
    tests_run += 5;
    if (mk !== 8'hFF) begin tests_failed++; $display("FAIL sd_mask got %b exp 11111111", mk); end
    if (ma !== 16'h0100) begin tests_failed++; $display("FAIL sd_addr got %h exp 0100", ma); end
    if (mwd !== 64'h1122_3344_5566_7788) begin tests_failed++; $display("FAIL sd_wdata got %h exp 1122334455667788", mwd); end
    if (e !== 1'b0) begin tests_failed++; $display("FAIL sd_err got %b exp 0", e); end
    if (rd !== 64'd0) begin tests_failed++; $display("FAIL sd_rdata got %h exp 0", rd); end
    do_req(1'b0, 3'b011, 64'h0100, 64'd0, rd, e, mk, ma, mwd);
    tests_run += 3;
    if (rd !== 64'h1122_3344_5566_7788) begin tests_failed++; $display("FAIL ld_rdata got %h exp 1122334455667788", rd); end
    if (e !== 1'b0) begin tests_failed++; $display("FAIL ld_err got %b exp 0", e); end
    if (mk !== 8'd0) begin tests_failed++; $display("FAIL ld_mask got %b exp 0", mk); end
  endtask

  task automatic test_byte();
    logic [63:0] rd, mwd; logic e; logic [7:0] mk; logic [15:0] ma;
    do_req(1'b1, 3'b000, 64'h0103, 64'h0000_0000_0000_00AA, rd, e, mk, ma, mwd);
    tests_run++;
    if (mk !== 8'h01) begin tests_failed++; $display("FAIL sb_mask got %b exp 00000001", mk); end
    do_req(1'b0, 3'b000, 64'h0103, 64'd0, rd, e, mk, ma, mwd);
    tests_run++;
    if (rd !== 64'hFFFF_FFFF_FFFF_FFAA) begin tests_failed++; $display("FAIL lb_rdata got %h exp ffffffffffffffaa", rd); end
    do_req(1'b0, 3'b100, 64'h0103, 64'd0, rd, e, mk, ma, mwd);
    tests_run++;
    if (rd !== 64'h0000_0000_0000_00AA) begin tests_failed++; $display("FAIL lbu_rdata got %h exp 00000000000000aa", rd); end
    do_req(1'b0, 3'b011, 64'h0100, 64'd0, rd, e, mk, ma, mwd);
    tests_run++;
    if (rd !== 64'h1122_3344_AA66_7788) begin tests_failed++; $display("FAIL ld_after_sb got %h exp 11223344aa667788", rd); end
  endtask

  task automatic test_errors();
    logic [63:0] rd, mwd; logic e; logic [7:0] mk; logic [15:0] ma;
    do_req(1'b0, 3'b010, 64'h0102, 64'd0, rd, e, mk, ma, mwd);
    tests_run += 3;
    if (e !== 1'b1) begin tests_failed++; $display("FAIL lw_mis_err got %b exp 1", e); end
    if (rd !== 64'd0) begin tests_failed++; $display("FAIL lw_mis_rdata got %h exp 0", rd); end
    if (mk !== 8'd0) begin tests_failed++; $display("FAIL lw_mis_mask got %b exp 0", mk); end
    do_req(1'b1, 3'b001, 64'h0201, 64'h0000_0000_0000_BEEF, rd, e, mk, ma, mwd);
    tests_run += 3;
    if (e !== 1'b1) begin tests_failed++; $display("FAIL sh_mis_err got %b exp 1", e); end
    if (mk !== 8'd0) begin tests_failed++; $display("FAIL sh_mis_mask got %b exp 0", mk); end
    if ({mem[16'h0202], mem[16'h0201]} !== 16'h0000) begin
      tests_failed++; $display("FAIL sh_mis_mem got %h exp 0000", {mem[16'h0202], mem[16'h0201]});
    end
    do_req(1'b0, 3'b011, 64'h1_0000, 64'd0, rd, e, mk, ma, mwd);
    tests_run += 2;
    if (e !== 1'b1) begin tests_failed++; $display("FAIL ld_range_err got %b exp 1", e); end
    if (rd !== 64'd0) begin tests_failed++; $display("FAIL ld_range_rdata got %h exp 0", rd); end
    do_req(1'b0, 3'b111, 64'h0100, 64'd0, rd, e, mk, ma, mwd);
    tests_run++;
    if (e !== 1'b1) begin tests_failed++; $display("FAIL ld_f3_111_err got %b exp 1", e); end
    do_req(1'b1, 3'b100, 64'h0100, 64'h55, rd, e, mk, ma, mwd);
    tests_run += 2;
    if (e !== 1'b1) begin tests_failed++; $display("FAIL st_f3_100_err got %b exp 1", e); end
    if (mk !== 8'd0) begin tests_failed++; $display("FAIL st_f3_100_mask got %b exp 0", mk); end
  endtask

  task automatic test_word();
    logic [63:0] rd, mwd; logic e; logic [7:0] mk; logic [15:0] ma;
    do_req(1'b1, 3'b010, 64'h0008, 64'h0000_8000_8000_0001, rd, e, mk, ma, mwd);
    tests_run++;
    if (mk !== 8'h0F) begin tests_failed++; $display("FAIL sw_mask got %b exp 00001111", mk); end
    do_req(1'b0, 3'b110, 64'h0008, 64'd0, rd, e, mk, ma, mwd);
    tests_run++;
    if (rd !== 64'h0000_0000_8000_0001) begin tests_failed++; $display("FAIL lwu_rdata got %h exp 0000000080000001", rd); end
    do_req(1'b0, 3'b010, 64'h0008, 64'd0, rd, e, mk, ma, mwd);
    tests_run++;
    if (rd !== 64'hFFFF_FFFF_8000_0001) begin tests_failed++; $display("FAIL lw_rdata got %h exp ffffffff80000001", rd); end
    // High byte of the word store must not have spilled into 0x000C
    do_req(1'b0, 3'b011, 64'h0008, 64'd0, rd, e, mk, ma, mwd);
    tests_run++;
    if (rd !== 64'h0000_0000_8000_0001) begin tests_failed++; $display("FAIL ld_after_sw got %h exp 0000000080000001", rd); end
  endtask

  task automatic test_backpressure();
    logic [63:0] rd, mwd; logic e; logic [7:0] mk; logic [15:0] ma;
    logic seen;
    // 0x000A/0x000B hold 00/80 from the word store -> LH gives 0x8000 sign-extended
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b001; req_addr = 64'h000A; req_wdata = '0;
    @(posedge clk);
    #1;
    // Present a second request that must wait for the handshake
    req_funct3 = 3'b011; req_addr = 64'h0100;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (resp_valid) begin seen = 1'b1; break; end
    end
    tests_run++;
    if (!seen) begin tests_failed++; $display("FAIL bp_timeout got resp_valid=0 exp 1"); end
    for (int k = 0; k < 5; k++) begin
      tests_run += 4;
      if (resp_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_valid[%0d] got %b exp 1", k, resp_valid); end
      if (resp_rdata !== 64'hFFFF_FFFF_FFFF_8000) begin tests_failed++; $display("FAIL bp_rdata[%0d] got %h exp ffffffffffff8000", k, resp_rdata); end
      if (resp_err !== 1'b0) begin tests_failed++; $display("FAIL bp_err[%0d] got %b exp 0", k, resp_err); end
      if (req_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_req_ready[%0d] got %b exp 0", k, req_ready); end
      if (k < 4) @(negedge clk);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    resp_ready = 1'b0;
    tests_run += 2;
    if (resp_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_post_valid got %b exp 0", resp_valid); end
    if (req_ready !== 1'b1) begin tests_failed++; $display("FAIL bp_post_ready got %b exp 1", req_ready); end
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    tests_run += 2;
    if (req_ready !== 1'b0) begin tests_failed++; $display("FAIL bp_acc_ready got %b exp 0", req_ready); end
    if (resp_valid !== 1'b0) begin tests_failed++; $display("FAIL bp_acc_valid got %b exp 0", resp_valid); end
    @(negedge clk);
    tests_run += 2;
    if (resp_valid !== 1'b1) begin tests_failed++; $display("FAIL bp_2nd_valid got %b exp 1", resp_valid); end
    if (resp_rdata !== 64'h1122_3344_AA66_7788) begin tests_failed++; $display("FAIL bp_2nd_rdata got %h exp 11223344aa667788", resp_rdata); end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    // Port still usable afterwards
    do_req(1'b0, 3'b101, 64'h000A, 64'd0, rd, e, mk, ma, mwd);
    tests_run++;
    if (rd !== 64'h0000_0000_0000_8000) begin tests_failed++; $display("FAIL lhu_rdata got %h exp 0000000000008000", rd); end
  endtask

  initial begin
    tests_run = 0;
    tests_failed = 0;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
    req_addr = '0; req_wdata = '0; resp_ready = 1'b0;
    test_reset();
    test_reset_mid_access();
    test_sd_ld();
    test_byte();
    test_errors();
    test_word();
    test_backpressure();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
